game_timer: RTL

- Downstream consumer of the game-control FSM's `timer_en` and `game_status`.
- Measures elapsed play time as packed BCD MM:SS for the seven-segment display path.
- Clears when the player returns to board selection and freezes on a win.
- Optionally keeps a best (lowest) completion time across rounds.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_timer_if.sv | 22 ++
 rtl/game_timer_bcd_digit.sv | 25 ++
 rtl/game_timer.sv | 94 +++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types: status codes, BCD time widths and the saturation value.
// Used by the game FSM, the timer and the display driver.
package game_pkg;

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } status_e;

    localparam int BCD_W   = 4;
    localparam int TIME_W  = 16;
    localparam int NUM_DIG = TIME_W / BCD_W;

    // Packed MM:59 for a given minute limit (limit must be 0..99)
    function automatic logic [TIME_W-1:0] sat_bcd(input int max_min);
        return {BCD_W'(max_min / 10), BCD_W'(max_min % 10), 4'd5, 4'd9};
    endfunction

    localparam logic [TIME_W-1:0] MAX_TIME_BCD = sat_bcd(99);

endpackage

// File: rtl/game_timer_if.sv
// Control inputs from the game FSM and display-side outputs of game_timer.
interface game_timer_if;
    import game_pkg::*;

    logic              timer_en;
    status_e           game_status;
    logic [TIME_W-1:0] time_bcd;
    logic              sec_pulse;
    logic              saturated;
    logic [TIME_W-1:0] best_bcd;
    logic              new_record;

    modport master (
        output timer_en, game_status,
        input  time_bcd, sec_pulse, saturated, best_bcd, new_record
    );

    modport slave (
        input  timer_en, game_status,
        output time_bcd, sec_pulse, saturated, best_bcd, new_record
    );
endinterface

// File: rtl/game_timer_bcd_digit.sv
// One BCD digit counting 0..MODULUS-1; carry is combinational so a chain
// of digits ripples a single increment within one clock.
module bcd_digit
    import game_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic             clk_d,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    assign carry = inc && (digit == BCD_W'(MODULUS - 1));

    always_ff @(posedge clk_d) begin
        if (rst || clr)
            digit <= '0;
        else if (inc)
            digit <= carry ? '0 : digit + 1'b1;
    end

endmodule

// File: rtl/game_timer.sv
// Elapsed play time in packed BCD MM:SS, cleared on board selection, frozen
// on a win. Define GAME_TIMER_BEST_TIME_EN to keep the best completion time.
module game_timer
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int MAX_MIN       = 99
) (
    input  logic        clk_d,
    input  logic        rst,
    game_timer_if.slave tif
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]     PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [TIME_W-1:0] SAT_VAL  = sat_bcd(MAX_MIN);

    logic [PW-1:0]          prescaler;
    logic [NUM_DIG:0]       carry;
    logic [TIME_W-1:0]      time_q;
    logic                   clr, frozen, saturated, run, tick, sec_pulse_q;

    assign clr       = (tif.game_status == CHOSE_BOARD);
    assign frozen    = (tif.game_status == WINNED);
    assign saturated = (time_q == SAT_VAL);
    assign run       = tif.timer_en && !saturated && !frozen && !clr;
    assign tick      = run && (prescaler == PRE_LAST);

    always_ff @(posedge clk_d) begin
        if (rst || clr)
            prescaler <= '0;
        else if (run)
            prescaler <= tick ? '0 : prescaler + 1'b1;
    end

    always_ff @(posedge clk_d) begin
        if (rst)
            sec_pulse_q <= 1'b0;
        else
            sec_pulse_q <= tick;
    end

    // Ripple chain sec_ones -> sec_tens -> min_ones -> min_tens. A carry out
    // of min_tens cannot occur under saturation; if it did, restart at 00:00.
    assign carry[0] = tick;

    for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
        bcd_digit #(.MODULUS((i == 1) ? 6 : 10)) u_dig (
            .clk_d (clk_d),
            .rst   (rst),
            .inc   (carry[i]),
            .clr   (clr || carry[NUM_DIG]),
            .digit (time_q[i*BCD_W +: BCD_W]),
            .carry (carry[i+1])
        );
    end

    assign tif.time_bcd  = time_q;
    assign tif.sec_pulse = sec_pulse_q;
    assign tif.saturated = saturated;

`ifdef GAME_TIMER_BEST_TIME_EN
    status_e           status_q;
    logic              record_valid, new_record_q, win_entry;
    logic [TIME_W-1:0] best_q;

    // time_q is already frozen on the entry cycle, so it is the final time
    assign win_entry = frozen && (status_q != WINNED);

    always_ff @(posedge clk_d) begin
        if (rst) begin
            status_q     <= CHOSE_BOARD;
            record_valid <= 1'b0;
            best_q       <= '0;
            new_record_q <= 1'b0;
        end else begin
            status_q     <= tif.game_status;
            new_record_q <= 1'b0;
            if (win_entry && (!record_valid || time_q < best_q)) begin
                best_q       <= time_q;
                record_valid <= 1'b1;
                new_record_q <= 1'b1;
            end
        end
    end

    assign tif.best_bcd   = best_q;
    assign tif.new_record = new_record_q;
`else
    assign tif.best_bcd   = '0;
    assign tif.new_record = 1'b0;
`endif

endmodule
